// File: rtl/mdu_if.sv
// -----------------------------------------------------------------------------
// mdu_pkg / mdu_if
//
// mdu_pkg : decoded ALU op codes understood by the multiply/divide unit and the
//           unit's state encoding.
// mdu_if  : request/result bundle between the pipeline and the MDU.
//   start       request valid this cycle               (master -> slave)
//   alucontrol  8-bit decoded ALU op code              (master -> slave)
//   a           rs operand: dividend / multiplicand    (master -> slave)
//   b           rt operand: divisor / multiplier       (master -> slave)
//   cancel      abort a running division               (master -> slave)
//               present only when MDU_CANCEL_EN is defined
//   busy        operation in flight, stall request     (slave -> master)
//   done        one-cycle pulse, hi/lo hold new result (slave -> master)
//   hi          HI register: product high / remainder  (slave -> master)
//   lo          LO register: product low / quotient    (slave -> master)
// Optional feature macro: MDU_CANCEL_EN
// -----------------------------------------------------------------------------
package mdu_pkg;

  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

interface mdu_if;
  logic        start;
  logic [7:0]  alucontrol;
  logic [31:0] a;
  logic [31:0] b;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, alucontrol, a, b,
    input  busy, done, hi, lo
`ifdef MDU_CANCEL_EN
    , output cancel
`endif
  );

  modport slave (
    input  start, alucontrol, a, b,
    output busy, done, hi, lo
`ifdef MDU_CANCEL_EN
    , input cancel
`endif
  );
endinterface

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- MIPS-style multiply/divide unit with HI/LO result registers.
//
// Multiply (MULT/MULTU) takes one cycle in MUL. Divide (DIV/DIVU) is a radix-2
// restoring divider on 32-bit magnitudes, 32 cycles in DIV, with the signs
// fixed up on the final edge (quotient truncates toward zero, remainder takes
// the dividend's sign). A zero divisor finishes after a single DIV cycle with
// lo = all ones and hi = dividend. DONE lasts one cycle and may accept a new
// request directly.
//
// Ports:
//   clk   single clock, all state on the rising edge
//   rst   asynchronous, active-high reset
//   bus   mdu_if.slave: start/alucontrol/a/b(/cancel) in, busy/done/hi/lo out
// Optional feature macro: MDU_CANCEL_EN (cancel aborts a running division)
// -----------------------------------------------------------------------------
module mdu
  import mdu_pkg::*;
(
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);

  mdu_state_e  state_q, state_d;

  logic [31:0] a_q, a_d;          // raw operands captured at acceptance
  logic [31:0] b_q, b_d;
  logic        signed_q, signed_d;
  logic [31:0] rem_q, rem_d;      // partial remainder
  logic [31:0] quo_q, quo_d;      // dividend magnitude shifting out, quotient in
  logic [4:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        op_mul, op_div, op_signed, accept, cancel_hit, div_last;
  logic        div_zero, q_neg, r_neg;
  logic [31:0] b_mag, rem_next, quo_next;
  logic [32:0] shifted, diff;
  logic [63:0] prod;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign op_mul    = (bus.alucontrol == EXE_MULT_OP) || (bus.alucontrol == EXE_MULTU_OP);
  assign op_div    = (bus.alucontrol == EXE_DIV_OP)  || (bus.alucontrol == EXE_DIVU_OP);
  assign op_signed = (bus.alucontrol == EXE_MULT_OP) || (bus.alucontrol == EXE_DIV_OP);
  assign accept    = bus.start && (op_mul || op_div) &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef MDU_CANCEL_EN
  assign cancel_hit = (state_q == ST_DIV) && bus.cancel;
`else
  assign cancel_hit = 1'b0;
`endif

  assign div_zero = (b_q == 32'd0);
  assign div_last = div_zero || (count_q == 5'd31);

  // ---------------------------------------------------------------------------
  // Arithmetic
  // ---------------------------------------------------------------------------
  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both signed and unsigned multiplies.
  assign prod = {{32{signed_q & a_q[31]}}, a_q} * {{32{signed_q & b_q[31]}}, b_q};

  assign b_mag = (signed_q && b_q[31]) ? -b_q : b_q;
  assign q_neg = signed_q && (a_q[31] ^ b_q[31]);
  assign r_neg = signed_q && a_q[31];

  // One restoring step: shift in the next dividend bit, try subtracting.
  assign shifted  = {rem_q, quo_q[31]};
  assign diff     = shifted - {1'b0, b_mag};
  assign rem_next = diff[32] ? shifted[31:0] : diff[31:0];
  assign quo_next = {quo_q[30:0], ~diff[32]};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: each combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = op_div ? ST_DIV : ST_MUL;
      ST_MUL:  state_d = ST_DONE;
      ST_DIV: begin
        if (cancel_hit)    state_d = ST_IDLE;   // cancel beats completion
        else if (div_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = accept ? (op_div ? ST_DIV : ST_MUL) : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      ST_MUL, ST_DIV: bus.busy = 1'b1;
      ST_DONE:        bus.done = 1'b1;
      default:        ;
    endcase
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (accept) begin
      a_d      = bus.a;
      b_d      = bus.b;
      signed_d = op_signed;
      rem_d    = 32'd0;
      quo_d    = (op_signed && bus.a[31]) ? -bus.a : bus.a;
      count_d  = 5'd0;
    end else if (state_q == ST_MUL) begin
      {hi_d, lo_d} = prod;
    end else if (state_q == ST_DIV && !cancel_hit) begin
      if (div_zero) begin
        lo_d = 32'hFFFF_FFFF;
        hi_d = a_q;
      end else begin
        rem_d   = rem_next;
        quo_d   = quo_next;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          lo_d = q_neg ? -quo_next : quo_next;
          hi_d = r_neg ? -rem_next : rem_next;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      signed_q <= 1'b0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      count_q  <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule
